// File: rtl/swt16_pkg.sv
// Shared swt16 definitions: data memory geometry defaults and arbiter encodings.
// Imported by the data memory arbiter.
package swt16_pkg;

   localparam int DMEM_ADDR_WIDTH_DEF = 12;
   localparam int DMEM_WORD_WIDTH_DEF = 16;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_SPLIT = 1'b1
   } arb_state_e;

   // Which requester owns the read data coming back from the SRAM next cycle.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CORE = 2'd1,
      OWN_DBG  = 2'd2
   } rd_owner_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the exec-stage core and a debug port.
// Core normally wins; a starved debug request eventually preempts it.
module dmem_arbiter
   import swt16_pkg::*;
#(
   parameter int DMEM_ADDR_WIDTH = DMEM_ADDR_WIDTH_DEF,
   parameter int DMEM_WORD_WIDTH = DMEM_WORD_WIDTH_DEF,
   parameter int STARVE_LIMIT    = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       in_core_load,
   input  logic                       in_core_store,
   input  logic [DMEM_ADDR_WIDTH-1:0] in_core_rd_addr,
   input  logic [DMEM_ADDR_WIDTH-1:0] in_core_wr_addr,
   input  logic [DMEM_WORD_WIDTH-1:0] in_core_wr_word,
   input  logic                       in_dbg_req,
   input  logic                       in_dbg_we,
   input  logic [DMEM_ADDR_WIDTH-1:0] in_dbg_addr,
   input  logic [DMEM_WORD_WIDTH-1:0] in_dbg_wr_word,
   input  logic [DMEM_WORD_WIDTH-1:0] in_mem_rd_word,
   output logic [DMEM_ADDR_WIDTH-1:0] out_mem_addr,
   output logic                       out_mem_wr_en,
   output logic [DMEM_WORD_WIDTH-1:0] out_mem_wr_word,
   output logic [DMEM_WORD_WIDTH-1:0] out_core_rd_word,
   output logic                       out_core_stall,
   output logic                       out_dbg_ack,
   output logic [DMEM_WORD_WIDTH-1:0] out_dbg_rd_word,
   output logic                       out_dbg_rd_valid
);

   localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   arb_state_e       state_q, state_d;
   logic [CNT_W-1:0] starve_q, starve_d;
   rd_owner_e        rd_owner_q, rd_owner_d;
   logic             core_req;
   logic             dbg_grant;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ARB_IDLE;
         starve_q   <= '0;
         rd_owner_q <= OWN_NONE;
      end else begin
         state_q    <= state_d;
         starve_q   <= starve_d;
         rd_owner_q <= rd_owner_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      starve_d        = '0;
      rd_owner_d      = OWN_NONE;
      core_req        = in_core_load | in_core_store;
      dbg_grant       = 1'b0;
      out_mem_addr    = '0;
      out_mem_wr_en   = 1'b0;
      out_mem_wr_word = '0;
      out_core_stall  = 1'b0;
      out_dbg_ack     = 1'b0;

      // Outputs are forced to zero for the whole time reset is held.
      if (!reset) begin
         case (state_q)
            ARB_SPLIT: begin
               // Second half of a load+store pair: the load goes out regardless of debug.
               out_mem_addr = in_core_rd_addr;
               rd_owner_d   = OWN_CORE;
               state_d      = ARB_IDLE;
            end
            default: begin
               if (core_req && (starve_q < LIMIT)) begin
                  if (in_core_load && in_core_store) begin
                     out_mem_addr    = in_core_wr_addr;
                     out_mem_wr_en   = 1'b1;
                     out_mem_wr_word = in_core_wr_word;
                     out_core_stall  = 1'b1;
                     state_d         = ARB_SPLIT;
                  end else if (in_core_store) begin
                     out_mem_addr    = in_core_wr_addr;
                     out_mem_wr_en   = 1'b1;
                     out_mem_wr_word = in_core_wr_word;
                  end else begin
                     out_mem_addr = in_core_rd_addr;
                     rd_owner_d   = OWN_CORE;
                  end
               end else if (in_dbg_req) begin
                  dbg_grant      = 1'b1;
                  out_dbg_ack    = 1'b1;
                  out_core_stall = core_req;
                  out_mem_addr   = in_dbg_addr;
                  if (in_dbg_we) begin
                     out_mem_wr_en   = 1'b1;
                     out_mem_wr_word = in_dbg_wr_word;
                  end else begin
                     rd_owner_d = OWN_DBG;
                  end
               end
            end
         endcase

         if (in_dbg_req && !dbg_grant) begin
            starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + 1'b1;
         end
      end

      out_core_rd_word = (rd_owner_q == OWN_CORE) ? in_mem_rd_word : '0;
      out_dbg_rd_valid = (rd_owner_q == OWN_DBG);
      out_dbg_rd_word  = (rd_owner_q == OWN_DBG) ? in_mem_rd_word : '0;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a ROM-style 1-cycle SRAM model.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_dmem_arbiter;

   logic        clock;
   logic        reset;
   logic        in_core_load;
   logic        in_core_store;
   logic [11:0] in_core_rd_addr;
   logic [11:0] in_core_wr_addr;
   logic [15:0] in_core_wr_word;
   logic        in_dbg_req;
   logic        in_dbg_we;
   logic [11:0] in_dbg_addr;
   logic [15:0] in_dbg_wr_word;
   logic [15:0] in_mem_rd_word;
   logic [11:0] out_mem_addr;
   logic        out_mem_wr_en;
   logic [15:0] out_mem_wr_word;
   logic [15:0] out_core_rd_word;
   logic        out_core_stall;
   logic        out_dbg_ack;
   logic [15:0] out_dbg_rd_word;
   logic        out_dbg_rd_valid;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [15:0] exp_q[$];
   logic [15:0] dbg_q[$];

   dmem_arbiter u_dut (
      .clock            (clock),
      .reset            (reset),
      .in_core_load     (in_core_load),
      .in_core_store    (in_core_store),
      .in_core_rd_addr  (in_core_rd_addr),
      .in_core_wr_addr  (in_core_wr_addr),
      .in_core_wr_word  (in_core_wr_word),
      .in_dbg_req       (in_dbg_req),
      .in_dbg_we        (in_dbg_we),
      .in_dbg_addr      (in_dbg_addr),
      .in_dbg_wr_word   (in_dbg_wr_word),
      .in_mem_rd_word   (in_mem_rd_word),
      .out_mem_addr     (out_mem_addr),
      .out_mem_wr_en    (out_mem_wr_en),
      .out_mem_wr_word  (out_mem_wr_word),
      .out_core_rd_word (out_core_rd_word),
      .out_core_stall   (out_core_stall),
      .out_dbg_ack      (out_dbg_ack),
      .out_dbg_rd_word  (out_dbg_rd_word),
      .out_dbg_rd_valid (out_dbg_rd_valid)
   );

   // ---------------- clock / reset / memory model ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [15:0] pat(input logic [11:0] a);
      if (a == 12'h010) return 16'hBEEF;
      return {a[3:0], a};
   endfunction

   always @(posedge clock) in_mem_rd_word <= pat(out_mem_addr);

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1);
   end

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      in_core_load    = 1'b0;
      in_core_store   = 1'b0;
      in_core_rd_addr = '0;
      in_core_wr_addr = '0;
      in_core_wr_word = '0;
      in_dbg_req      = 1'b0;
      in_dbg_we       = 1'b0;
      in_dbg_addr     = '0;
      in_dbg_wr_word  = '0;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset           = 1'b1;
      in_core_load    = 1'b1;
      in_core_store   = 1'b1;
      in_core_rd_addr = 12'h123;
      in_core_wr_addr = 12'h456;
      in_core_wr_word = 16'hFFFF;
      in_dbg_req      = 1'b1;
      in_dbg_addr     = 12'h789;
      step();
      #1;
      total_cnt++;
      if ({out_mem_addr, out_mem_wr_en, out_mem_wr_word, out_core_rd_word, out_core_stall,
           out_dbg_ack, out_dbg_rd_word, out_dbg_rd_valid} !== '0)
         $display("FAIL reset_outputs: got addr=%h we=%b wd=%h crd=%h stall=%b ack=%b drd=%h dv=%b, want all 0",
                  out_mem_addr, out_mem_wr_en, out_mem_wr_word, out_core_rd_word, out_core_stall,
                  out_dbg_ack, out_dbg_rd_word, out_dbg_rd_valid);
      else pass_cnt++;
      idle_inputs();
      step();
      reset = 1'b0;
      #1;
      total_cnt++;
      if ({out_mem_addr, out_mem_wr_en, out_mem_wr_word, out_core_stall, out_dbg_ack} !== '0)
         $display("FAIL idle_unowned: got addr=%h we=%b wd=%h stall=%b ack=%b, want all 0",
                  out_mem_addr, out_mem_wr_en, out_mem_wr_word, out_core_stall, out_dbg_ack);
      else pass_cnt++;
   endtask

   task automatic test_core_load();
      in_core_load    = 1'b1;
      in_core_rd_addr = 12'h010;
      exp_q.push_back(16'hBEEF);
      #1;
      total_cnt++;
      if (out_mem_addr !== 12'h010 || out_mem_wr_en !== 1'b0 || out_core_stall !== 1'b0)
         $display("FAIL core_load_issue: got addr=%h we=%b stall=%b, want 010 0 0",
                  out_mem_addr, out_mem_wr_en, out_core_stall);
      else pass_cnt++;
      step();
      idle_inputs();
      total_cnt++;
      if (out_core_rd_word !== exp_q[0])
         $display("FAIL core_load_data: got %h, want %h", out_core_rd_word, exp_q[0]);
      else pass_cnt++;
      void'(exp_q.pop_front());
      step();
      total_cnt++;
      if (out_core_rd_word !== 16'h0000)
         $display("FAIL core_rd_idle: got %h, want 0000", out_core_rd_word);
      else pass_cnt++;
   endtask

   task automatic test_split();
      in_core_load    = 1'b1;
      in_core_store   = 1'b1;
      in_core_rd_addr = 12'h020;
      in_core_wr_addr = 12'h030;
      in_core_wr_word = 16'h1234;
      #1;
      total_cnt++;
      if (out_mem_addr !== 12'h030 || out_mem_wr_en !== 1'b1 || out_mem_wr_word !== 16'h1234 ||
          out_core_stall !== 1'b1)
         $display("FAIL split_store: got addr=%h we=%b wd=%h stall=%b, want 030 1 1234 1",
                  out_mem_addr, out_mem_wr_en, out_mem_wr_word, out_core_stall);
      else pass_cnt++;
      step();
      #1;
      total_cnt++;
      if (out_mem_addr !== 12'h020 || out_mem_wr_en !== 1'b0 || out_core_stall !== 1'b0)
         $display("FAIL split_load: got addr=%h we=%b stall=%b, want 020 0 0",
                  out_mem_addr, out_mem_wr_en, out_core_stall);
      else pass_cnt++;
      exp_q.push_back(pat(12'h020));
      step();
      idle_inputs();
      total_cnt++;
      if (out_core_rd_word !== exp_q[0])
         $display("FAIL split_load_data: got %h, want %h", out_core_rd_word, exp_q[0]);
      else pass_cnt++;
      void'(exp_q.pop_front());
   endtask

   task automatic test_dbg_write();
      in_dbg_req     = 1'b1;
      in_dbg_we      = 1'b1;
      in_dbg_addr    = 12'h005;
      in_dbg_wr_word = 16'hA5A5;
      #1;
      total_cnt++;
      if (out_dbg_ack !== 1'b1 || out_mem_wr_en !== 1'b1 || out_mem_addr !== 12'h005 ||
          out_mem_wr_word !== 16'hA5A5 || out_core_stall !== 1'b0)
         $display("FAIL dbg_write: got ack=%b we=%b addr=%h wd=%h stall=%b, want 1 1 005 a5a5 0",
                  out_dbg_ack, out_mem_wr_en, out_mem_addr, out_mem_wr_word, out_core_stall);
      else pass_cnt++;
      step();
      idle_inputs();
      total_cnt++;
      if (out_dbg_rd_valid !== 1'b0 || out_dbg_rd_word !== 16'h0000)
         $display("FAIL dbg_write_no_valid: got valid=%b word=%h, want 0 0000",
                  out_dbg_rd_valid, out_dbg_rd_word);
      else pass_cnt++;
   endtask

   task automatic test_starve();
      logic [11:0] a;
      bit          granted;
      bit          acked;
      granted     = 1'b0;
      in_dbg_req  = 1'b1;
      in_dbg_we   = 1'b0;
      in_dbg_addr = 12'h040;
      for (int i = 1; i <= 8 && !granted; i++) begin
         a               = 12'h100 + 12'(i);
         in_core_load    = 1'b1;
         in_core_rd_addr = a;
         #1;
         acked = out_dbg_ack;
         total_cnt++;
         if (out_dbg_ack !== (i == 5))
            $display("FAIL starve_ack_c%0d: got %b, want %b", i, out_dbg_ack, (i == 5));
         else pass_cnt++;
         if (acked) begin
            granted = 1'b1;
            dbg_q.push_back(pat(12'h040));
            total_cnt++;
            if (out_mem_addr !== 12'h040 || out_core_stall !== 1'b1)
               $display("FAIL starve_preempt: got addr=%h stall=%b, want 040 1",
                        out_mem_addr, out_core_stall);
            else pass_cnt++;
         end else begin
            exp_q.push_back(pat(a));
            total_cnt++;
            if (out_mem_addr !== a || out_core_stall !== 1'b0)
               $display("FAIL starve_core_c%0d: got addr=%h stall=%b, want %h 0",
                        i, out_mem_addr, out_core_stall, a);
            else pass_cnt++;
         end
         step();
         if (acked) begin
            idle_inputs();
            total_cnt++;
            if (out_dbg_rd_valid !== 1'b1 || out_dbg_rd_word !== dbg_q[0] || out_core_rd_word !== 16'h0)
               $display("FAIL starve_dbg_read: got valid=%b word=%h crd=%h, want 1 %h 0000",
                        out_dbg_rd_valid, out_dbg_rd_word, out_core_rd_word, dbg_q[0]);
            else pass_cnt++;
            void'(dbg_q.pop_front());
         end else begin
            total_cnt++;
            if (out_core_rd_word !== exp_q[0] || out_dbg_rd_valid !== 1'b0)
               $display("FAIL starve_core_data_c%0d: got %h valid=%b, want %h 0",
                        i, out_core_rd_word, out_dbg_rd_valid, exp_q[0]);
            else pass_cnt++;
            void'(exp_q.pop_front());
         end
      end
      if (!granted) begin
         total_cnt++;
         $display("FAIL starve_timeout: got no ack in 8 cycles, want ack on cycle 5");
      end
      idle_inputs();
   endtask

   task automatic test_counter_clear();
      // Debug held 3 cycles, dropped 1, then reasserted: the wait starts over.
      for (int i = 0; i <= 8; i++) begin
         in_core_load    = 1'b1;
         in_core_rd_addr = 12'h200 + 12'(i);
         in_dbg_req      = (i != 3);
         in_dbg_we       = 1'b0;
         in_dbg_addr     = 12'h050;
         #1;
         total_cnt++;
         if (out_dbg_ack !== (i == 8))
            $display("FAIL counter_clear_c%0d: got ack=%b, want %b", i, out_dbg_ack, (i == 8));
         else pass_cnt++;
         step();
      end
      idle_inputs();
      step();
   endtask

   task automatic test_split_blocks_dbg();
      in_core_load    = 1'b1;
      in_core_store   = 1'b1;
      in_core_rd_addr = 12'h0A0;
      in_core_wr_addr = 12'h0B0;
      in_core_wr_word = 16'h7777;
      in_dbg_req      = 1'b1;
      in_dbg_we       = 1'b0;
      in_dbg_addr     = 12'h0C0;
      #1;
      total_cnt++;
      if (out_dbg_ack !== 1'b0 || out_mem_wr_en !== 1'b1 || out_core_stall !== 1'b1)
         $display("FAIL sbd_store: got ack=%b we=%b stall=%b, want 0 1 1",
                  out_dbg_ack, out_mem_wr_en, out_core_stall);
      else pass_cnt++;
      step();
      #1;
      total_cnt++;
      if (out_dbg_ack !== 1'b0 || out_mem_addr !== 12'h0A0 || out_core_stall !== 1'b0)
         $display("FAIL sbd_split_load: got ack=%b addr=%h stall=%b, want 0 0a0 0",
                  out_dbg_ack, out_mem_addr, out_core_stall);
      else pass_cnt++;
      exp_q.push_back(pat(12'h0A0));
      step();
      in_core_load  = 1'b0;
      in_core_store = 1'b0;
      #1;
      total_cnt++;
      if (out_core_rd_word !== exp_q[0])
         $display("FAIL sbd_load_data: got %h, want %h", out_core_rd_word, exp_q[0]);
      else pass_cnt++;
      void'(exp_q.pop_front());
      total_cnt++;
      if (out_dbg_ack !== 1'b1 || out_mem_addr !== 12'h0C0 || out_core_stall !== 1'b0)
         $display("FAIL sbd_dbg_alone: got ack=%b addr=%h stall=%b, want 1 0c0 0",
                  out_dbg_ack, out_mem_addr, out_core_stall);
      else pass_cnt++;
      dbg_q.push_back(pat(12'h0C0));
      step();
      idle_inputs();
      total_cnt++;
      if (out_dbg_rd_valid !== 1'b1 || out_dbg_rd_word !== dbg_q[0])
         $display("FAIL sbd_dbg_read: got valid=%b word=%h, want 1 %h",
                  out_dbg_rd_valid, out_dbg_rd_word, dbg_q[0]);
      else pass_cnt++;
      void'(dbg_q.pop_front());
      step();
   endtask

   task automatic test_reset_in_split();
      in_core_load    = 1'b1;
      in_core_store   = 1'b1;
      in_core_rd_addr = 12'h060;
      in_core_wr_addr = 12'h070;
      in_core_wr_word = 16'h4321;
      step();
      reset = 1'b1;
      #1;
      total_cnt++;
      if ({out_mem_addr, out_mem_wr_en, out_mem_wr_word, out_core_rd_word, out_core_stall,
           out_dbg_ack, out_dbg_rd_word, out_dbg_rd_valid} !== '0)
         $display("FAIL split_reset_outputs: got addr=%h we=%b stall=%b, want all 0",
                  out_mem_addr, out_mem_wr_en, out_core_stall);
      else pass_cnt++;
      step();
      idle_inputs();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         total_cnt++;
         if (out_mem_addr !== 12'h0 || out_core_rd_word !== 16'h0 || out_dbg_rd_valid !== 1'b0)
            $display("FAIL split_reset_after_c%0d: got addr=%h crd=%h dv=%b, want 000 0000 0",
                     i, out_mem_addr, out_core_rd_word, out_dbg_rd_valid);
         else pass_cnt++;
         step();
      end
   endtask

   task automatic test_random_loads();
      logic [11:0] a;
      bit          ld;
      for (int i = 0; i < 16; i++) begin
         ld              = 1'($urandom_range(0, 1));
         a               = 12'($urandom_range(0, 4095));
         in_core_load    = ld;
         in_core_rd_addr = a;
         #1;
         total_cnt++;
         if (out_mem_addr !== (ld ? a : 12'h0) || out_mem_wr_en !== 1'b0)
            $display("FAIL rand_addr_%0d: got addr=%h we=%b, want %h 0",
                     i, out_mem_addr, out_mem_wr_en, (ld ? a : 12'h0));
         else pass_cnt++;
         if (ld) exp_q.push_back(pat(a));
         step();
         total_cnt++;
         if (ld) begin
            if (out_core_rd_word !== exp_q[0])
               $display("FAIL rand_data_%0d: got %h, want %h", i, out_core_rd_word, exp_q[0]);
            else pass_cnt++;
            void'(exp_q.pop_front());
         end else begin
            if (out_core_rd_word !== 16'h0)
               $display("FAIL rand_nodata_%0d: got %h, want 0000", i, out_core_rd_word);
            else pass_cnt++;
         end
      end
      idle_inputs();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_core_load();
      test_split();
      test_dbg_write();
      test_starve();
      test_counter_clear();
      test_split_blocks_dbg();
      test_reset_in_split();
      test_random_loads();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
